// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file with busy scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

    // Index of the hardwired-zero register.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: issue sets, late writeback clears, flush clears all.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS),
    parameter int unsigned NRP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              flush,
    input  logic [NRP*AW-1:0] lk_addr,
    output logic [NRP-1:0]    lk_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Applied lowest priority first so that a same-cycle issue always wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (iss_en && iss_addr != AW'(REG_ZERO)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_lookup
        assign lk_busy[k] = busy_q[lk_addr[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with an ALU write port, a late write port and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wa_en,
    input  logic [AW-1:0]       wa_addr,
    input  logic [XLEN-1:0]     wa_data,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NRP-1:0]  sb_busy;

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .NRP   (NRP)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .flush    (flush),
        .lk_addr  (rd_addr),
        .lk_busy  (sb_busy)
    );

    // Port A is applied after port B so it wins a same-index collision.
    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != AW'(REG_ZERO)) begin
            regs_d[wb_addr] = wb_data;
        end
        if (wa_en && wa_addr != AW'(REG_ZERO)) begin
            regs_d[wa_addr] = wa_data;
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            live;
        logic            wa_hit;
        logic            wb_hit;
        logic [XLEN-1:0] data;

        assign addr   = rd_addr[k*AW +: AW];
        assign live   = (addr != AW'(REG_ZERO));
        assign wa_hit = (BYPASS != 0) && wa_en && (wa_addr == addr) && live;
        assign wb_hit = (BYPASS != 0) && wb_en && (wb_addr == addr) && live;

        always_comb begin
            data = regs_q[addr];
            if (wa_hit) begin
                data = wa_data;
            end else if (wb_hit) begin
                data = wb_data;
            end
        end

        // A returning result unblocks its consumer in the same cycle when bypassing.
        assign rd_data[k*XLEN +: XLEN] = reset ? '0 : data;
        assign rd_busy[k]              = ~reset & sb_busy[k] & ~wb_hit;
    end

endmodule
